// File: rtl/pipe3_exec_core.sv
// Three-stage (I -> A -> W) integer execution core with W-to-A operand forwarding,
// a small register file, hold/flush control, a retire counter and a sticky illegal flag.
module pipe3_exec_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  output logic            in_ready,
  input  logic            hold,
  input  logic            flush,
  output logic            wb_valid,
  output logic [3:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic [3:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     retire_count,
  output logic            illegal
);

  localparam int unsigned RegAw = $clog2(NREGS);

  // Pipeline state
  logic                  r_i_valid;
  logic [31:0]           r_i_instr;
  logic                  r_a_valid;
  logic [31:0]           r_a_instr;
  logic                  r_w_valid;
  logic [3:0]            r_w_op;
  logic [RegAw-1:0]      r_w_rd;
  logic [XLEN-1:0]       r_w_data;
  logic [XLEN-1:0]       r_regs [NREGS];
  logic [31:0]           r_retire_count;
  logic                  r_illegal;

  logic                  w_accept;
  logic [3:0]            w_a_op;
  logic [RegAw-1:0]      w_a_rd;
  logic [RegAw-1:0]      w_a_rs1;
  logic [RegAw-1:0]      w_a_rs2;
  logic [15:0]           w_a_imm;
  logic [XLEN-1:0]       w_op1;
  logic [XLEN-1:0]       w_op2;
  logic [XLEN-1:0]       w_alu;
  logic                  w_w_writes;
  logic                  w_w_is_illegal;
  logic                  w_retire;
  logic                  w_wb_fire;
  logic                  w_fwd1;
  logic                  w_fwd2;
  logic                  w_dbg_in_range;

  assign in_ready  = !hold && !flush;
  assign w_accept  = in_valid && in_ready;

  assign w_a_op    = r_a_instr[31:28];
  assign w_a_rd    = r_a_instr[24 +: RegAw];
  assign w_a_rs1   = r_a_instr[20 +: RegAw];
  assign w_a_rs2   = r_a_instr[16 +: RegAw];
  assign w_a_imm   = r_a_instr[15:0];

  assign w_w_writes     = r_w_valid && (r_w_op != 4'd0) && (r_w_op <= 4'd8);
  assign w_w_is_illegal = r_w_valid && (r_w_op > 4'd8);
  assign w_retire       = r_w_valid && !hold;
  assign w_wb_fire      = w_w_writes && !hold;

  // Forward the not-yet-written W result so dependent back-to-back ops need no bubble.
  assign w_fwd1 = w_w_writes && (w_a_rs1 != '0) && (r_w_rd == w_a_rs1);
  assign w_fwd2 = w_w_writes && (w_a_rs2 != '0) && (r_w_rd == w_a_rs2);
  assign w_op1  = w_fwd1 ? r_w_data : r_regs[w_a_rs1];
  assign w_op2  = w_fwd2 ? r_w_data : r_regs[w_a_rs2];

  always_comb begin
    w_alu = '0;
    case (w_a_op)
      4'd1:    w_alu = w_op1 + w_op2;
      4'd2:    w_alu = w_op1 - w_op2;
      4'd3:    w_alu = w_op1 & w_op2;
      4'd4:    w_alu = w_op1 | w_op2;
      4'd5:    w_alu = w_op1 ^ w_op2;
      4'd6:    w_alu = w_op1 + XLEN'({{48{w_a_imm[15]}}, w_a_imm});
      4'd7:    w_alu = XLEN'({w_a_imm, 16'h0000});
      4'd8:    w_alu = ($signed(w_op1) < $signed(w_op2)) ? XLEN'(1) : '0;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_valid      <= 1'b0;
      r_i_instr      <= '0;
      r_a_valid      <= 1'b0;
      r_a_instr      <= '0;
      r_w_valid      <= 1'b0;
      r_w_op         <= '0;
      r_w_rd         <= '0;
      r_w_data       <= '0;
      r_retire_count <= '0;
      r_illegal      <= 1'b0;
    end else begin
      // Flush clears I/A even while holding; W only moves when not held.
      if (flush) begin
        r_i_valid <= 1'b0;
        r_a_valid <= 1'b0;
      end else if (!hold) begin
        r_i_valid <= w_accept;
        if (w_accept) r_i_instr <= instruction;
        r_a_valid <= r_i_valid;
        r_a_instr <= r_i_instr;
      end
      if (!hold) begin
        r_w_valid <= r_a_valid && !flush;
        if (r_a_valid && !flush) begin
          r_w_op   <= w_a_op;
          r_w_rd   <= w_a_rd;
          r_w_data <= w_alu;
        end
      end
      if (w_retire) begin
        r_retire_count <= r_retire_count + 32'd1;
        if (w_w_is_illegal) r_illegal <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NREGS); k++) r_regs[k] <= '0;
    end else if (w_wb_fire && (r_w_rd != '0)) begin
      r_regs[r_w_rd] <= r_w_data;
    end
  end

  assign w_dbg_in_range = (32'(dbg_addr) < NREGS) && (dbg_addr != 4'd0);
  assign dbg_data       = w_dbg_in_range ? r_regs[dbg_addr[RegAw-1:0]] : '0;

  assign wb_valid     = w_wb_fire;
  assign wb_rd        = 4'(r_w_rd);
  assign wb_data      = r_w_data;
  assign retire_count = r_retire_count;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_pipe3_exec_core.sv
// Directed bench for pipe3_exec_core: a table of back-to-back instructions with
// hand-computed writebacks, then hold, flush and mid-flight reset sequences.
module tb_pipe3_exec_core;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] instruction;
  logic        in_ready;
  logic        hold;
  logic        flush;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] retire_count;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  pipe3_exec_core #(.XLEN(32), .NREGS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .instruction  (instruction),
    .in_ready     (in_ready),
    .hold         (hold),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .retire_count (retire_count),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        exp_v;
    logic [3:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  localparam int N = 14;
  vec_t vecs [N];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] a, input logic [31:0] exp, input string name);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    vecs[0]  = '{enc(4'd6, 4'd1, 4'd0, 4'd0, 16'd5),      1'b1, 4'd1,  32'd5};
    vecs[1]  = '{enc(4'd1, 4'd2, 4'd1, 4'd1, 16'd0),      1'b1, 4'd2,  32'd10};
    vecs[2]  = '{enc(4'd2, 4'd3, 4'd0, 4'd1, 16'd0),      1'b1, 4'd3,  32'hFFFF_FFFB};
    vecs[3]  = '{enc(4'd8, 4'd4, 4'd3, 4'd1, 16'd0),      1'b1, 4'd4,  32'd1};
    vecs[4]  = '{enc(4'd3, 4'd5, 4'd2, 4'd3, 16'd0),      1'b1, 4'd5,  32'd10};
    vecs[5]  = '{enc(4'd4, 4'd6, 4'd2, 4'd1, 16'd0),      1'b1, 4'd6,  32'd15};
    vecs[6]  = '{enc(4'd5, 4'd7, 4'd6, 4'd2, 16'd0),      1'b1, 4'd7,  32'd5};
    vecs[7]  = '{enc(4'd7, 4'd8, 4'd0, 4'd0, 16'h1234),   1'b1, 4'd8,  32'h1234_0000};
    vecs[8]  = '{enc(4'd6, 4'd9, 4'd8, 4'd0, 16'hFFFF),   1'b1, 4'd9,  32'h1233_FFFF};
    vecs[9]  = '{enc(4'd6, 4'd0, 4'd0, 4'd0, 16'd7),      1'b1, 4'd0,  32'd7};
    vecs[10] = '{enc(4'd0, 4'd10, 4'd1, 4'd1, 16'd0),     1'b0, 4'd0,  32'd0};
    vecs[11] = '{enc(4'hF, 4'd11, 4'd1, 4'd1, 16'd0),     1'b0, 4'd0,  32'd0};
    vecs[12] = '{enc(4'd8, 4'd10, 4'd1, 4'd3, 16'd0),     1'b1, 4'd10, 32'd0};
    vecs[13] = '{enc(4'd2, 4'd11, 4'd1, 4'd1, 16'd0),     1'b1, 4'd11, 32'd0};

    reset = 1'b1; in_valid = 1'b0; instruction = '0; hold = 1'b0; flush = 1'b0;
    dbg_addr = 4'd0;
    #2;
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.retire_count", retire_count, 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    step();
    reset = 1'b0;

    // Back-to-back stream; instruction k-2 sits in W after the edge that accepts k.
    for (int k = 0; k < N + 2; k++) begin
      in_valid    = (k < N);
      instruction = (k < N) ? vecs[k].instr : 32'd0;
      step();
      if (k >= 2) begin
        check($sformatf("vec%0d.wb_valid", k - 2), 32'(wb_valid), 32'(vecs[k-2].exp_v));
        if (vecs[k-2].exp_v) begin
          check($sformatf("vec%0d.wb_rd", k - 2), 32'(wb_rd), 32'(vecs[k-2].exp_rd));
          check($sformatf("vec%0d.wb_data", k - 2), wb_data, vecs[k-2].exp_data);
        end
      end
    end
    in_valid = 1'b0;
    step();
    check("stream.retire_count", retire_count, 32'd14);
    check("stream.illegal", 32'(illegal), 32'd1);
    peek(4'd0, 32'd0, "dbg.r0");
    peek(4'd1, 32'd5, "dbg.r1");
    peek(4'd3, 32'hFFFF_FFFB, "dbg.r3");
    peek(4'd4, 32'd1, "dbg.r4");
    peek(4'd9, 32'h1233_FFFF, "dbg.r9");

    // Hold with three in flight
    for (int k = 0; k < 3; k++) begin
      in_valid    = 1'b1;
      instruction = enc(4'd6, 4'(12 + k), 4'd0, 4'd0, 16'(k + 1));
      step();
    end
    hold = 1'b1;
    instruction = enc(4'd6, 4'd15, 4'd0, 4'd0, 16'd99);
    #1;
    check("hold.in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold%0d.wb_valid", k), 32'(wb_valid), 32'd0);
    end
    check("hold.retire_count", retire_count, 32'd14);
    check("hold.wb_rd", 32'(wb_rd), 32'd12);
    peek(4'd12, 32'd0, "hold.dbg.r12");
    hold = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("rel%0d.wb_valid", k), 32'(wb_valid), 32'd1);
      check($sformatf("rel%0d.wb_rd", k), 32'(wb_rd), 32'(12 + k));
      check($sformatf("rel%0d.wb_data", k), wb_data, 32'(k + 1));
      step();
    end
    check("rel.wb_valid_after", 32'(wb_valid), 32'd0);
    check("rel.retire_count", retire_count, 32'd17);
    peek(4'd14, 32'd3, "rel.dbg.r14");
    peek(4'd15, 32'd0, "rel.dbg.r15");

    // Flush with three in flight
    for (int k = 0; k < 3; k++) begin
      in_valid    = 1'b1;
      instruction = enc(4'd6, 4'(1 + k), 4'd0, 4'd0, 16'(8'h21 + k));
      step();
    end
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush.in_ready", 32'(in_ready), 32'd0);
    check("flush.wb_valid", 32'(wb_valid), 32'd1);
    step();
    flush = 1'b0;
    check("flush.retire_count", retire_count, 32'd18);
    check("flush.bubble", 32'(wb_valid), 32'd0);
    in_valid = 1'b1; instruction = enc(4'd6, 4'd5, 4'd0, 4'd0, 16'h55);
    step();
    in_valid = 1'b0;
    check("post_flush.c1", 32'(wb_valid), 32'd0);
    step();
    check("post_flush.c2", 32'(wb_valid), 32'd0);
    step();
    check("post_flush.wb_valid", 32'(wb_valid), 32'd1);
    check("post_flush.wb_rd", 32'(wb_rd), 32'd5);
    check("post_flush.wb_data", wb_data, 32'h55);
    step();
    check("post_flush.retire_count", retire_count, 32'd19);
    peek(4'd1, 32'h21, "flush.dbg.r1");
    peek(4'd2, 32'd10, "flush.dbg.r2");
    peek(4'd3, 32'hFFFF_FFFB, "flush.dbg.r3");

    // Reset with pipe full
    for (int k = 0; k < 3; k++) begin
      in_valid    = 1'b1;
      instruction = enc(4'd6, 4'(6 + k), 4'd0, 4'd0, 16'(8'h66 + k));
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mrst.wb_valid", 32'(wb_valid), 32'd0);
    check("mrst.wb_rd", 32'(wb_rd), 32'd0);
    check("mrst.wb_data", wb_data, 32'd0);
    check("mrst.retire_count", retire_count, 32'd0);
    check("mrst.illegal", 32'(illegal), 32'd0);
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    peek(4'd1, 32'd0, "mrst.dbg.r1");
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("mrst_idle%0d.wb_valid", k), 32'(wb_valid), 32'd0);
    end
    check("mrst_idle.retire_count", retire_count, 32'd0);
    peek(4'd6, 32'd0, "mrst.dbg.r6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
